fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage ARM pipeline: owns the PC, runs a request/ready handshake to instruction memory, and drives the IF/ID boundary.
- Consumes the hazard detection unit's `hazard` output as a freeze and the EXE-stage branch redirect as a flush.
- Handles variable-latency memory. A stalled or flushed fetch is held in a skid buffer or drained, never dropped mid-handshake.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake
// and drives the IF/ID boundary, absorbing freezes (skid) and redirects (drain).
module fetch_stage #(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [ADDR_W-1:0]   redir, redir_n;
  logic [INSTR_W-1:0]  skid, skid_n;
  logic                if_valid_n;
  logic [ADDR_W-1:0]   if_pc_n;
  logic [INSTR_W-1:0]  if_instr_n;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & WORD_MASK;
  endfunction

  // The request stays up through FETCH and DRAIN so a started handshake always completes.
  assign imem_req  = rst && (state != HOLD);
  assign imem_addr = word_align(pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      redir    <= '0;
      skid     <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      redir    <= redir_n;
      skid     <= skid_n;
      if_valid <= if_valid_n;
      if_pc    <= if_pc_n;
      if_instr <= if_instr_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    redir_n    = redir;
    skid_n     = skid;
    if_valid_n = if_valid;
    if_pc_n    = if_pc;
    if_instr_n = if_instr;

    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          if (branch_taken) begin
            pc_n       = word_align(branch_addr);
            if_valid_n = 1'b0;
          end else if (hazard) begin
            skid_n  = imem_rdata;
            state_n = HOLD;
          end else begin
            if_instr_n = imem_rdata;
            if_pc_n    = pc + PC_STEP;
            if_valid_n = 1'b1;
            pc_n       = pc + PC_STEP;
          end
        end else begin
          if (branch_taken) begin
            // Memory still owes data for pc; remember the target until it drains.
            redir_n    = word_align(branch_addr);
            if_valid_n = 1'b0;
            state_n    = DRAIN;
          end else if (!hazard) begin
            if_valid_n = 1'b0;
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_n       = word_align(branch_addr);
          if_valid_n = 1'b0;
          state_n    = FETCH;
        end else if (!hazard) begin
          if_instr_n = skid;
          if_pc_n    = pc + PC_STEP;
          if_valid_n = 1'b1;
          pc_n       = pc + PC_STEP;
          state_n    = FETCH;
        end
      end

      DRAIN: begin
        if_valid_n = 1'b0;
        if (branch_taken) begin
          redir_n = word_align(branch_addr);
        end
        if (imem_ready) begin
          pc_n    = branch_taken ? word_align(branch_addr) : redir;
          state_n = FETCH;
        end
      end

      default: begin
        state_n    = FETCH;
        if_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  // Memory contents: identity in the directed part, a hash in the random part.
  bit mem_ident = 1'b1;

  // Behavioural model: a fetch is either in flight, parked (word captured
  // during a freeze), or owed-but-redirected (target remembered).
  logic [31:0] m_pc;
  bit          m_parked;
  logic [31:0] m_parked_word;
  bit          m_redirect;
  logic [31:0] m_target;
  bit          m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_iin;

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (mem_ident) return a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_parked = 0; m_parked_word = 0; m_redirect = 0; m_target = 0;
    m_v = 0; m_ipc = 0; m_iin = 0;
  endtask

  task automatic emit(input logic [31:0] word, input logic [31:0] next_pc);
    m_v = 1; m_iin = word; m_ipc = next_pc; m_pc = next_pc;
  endtask

  task automatic model_step(input logic h, input logic bt, input logic [31:0] ba, input logic rdy);
    logic [31:0] tgt;
    tgt = ba & ~32'd3;
    if (m_parked) begin
      if (bt) begin
        m_parked = 0; m_pc = tgt; m_v = 0;
      end else if (!h) begin
        m_parked = 0; emit(m_parked_word, m_pc + 32'd4);
      end
    end else if (m_redirect) begin
      m_v = 0;
      if (bt) m_target = tgt;
      if (rdy) begin
        m_pc = m_target; m_redirect = 0;
      end
    end else if (bt) begin
      m_v = 0;
      if (rdy) m_pc = tgt;
      else begin
        m_redirect = 1; m_target = tgt;
      end
    end else if (h) begin
      if (rdy) begin
        m_parked = 1; m_parked_word = mem(m_pc);
      end
    end else if (rdy) begin
      emit(mem(m_pc), m_pc + 32'd4);
    end else begin
      m_v = 0;
    end
  endtask

  task automatic compare();
    logic exp_req;
    exp_req = rst && !m_parked;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
    chk("if_pc", if_pc, m_ipc);
    chk("if_instr", if_instr, m_iin);
  endtask

  task automatic cycle(input logic r, input logic h, input logic bt,
                       input logic [31:0] ba, input logic rdy);
    @(negedge clk);
    rst = r; hazard = h; branch_taken = bt; branch_addr = ba; imem_ready = rdy;
    if (!r) model_reset();
    #1;
    imem_rdata = rdy ? mem(imem_addr) : $urandom;
    compare();
    @(posedge clk);
    if (r) model_step(h, bt, ba, rdy);
    #1;
  endtask

  initial begin
    rst = 1'b0; hazard = 0; branch_taken = 0; branch_addr = 0;
    imem_ready = 0; imem_rdata = 0;
    model_reset();

    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);

    // Streaming with same-cycle ready
    cycle(1, 0, 0, 0, 1);
    chk("s1_valid", {31'd0, if_valid}, 32'd1);
    chk("s1_pc", if_pc, 32'd4);
    chk("s1_instr", if_instr, 32'd0);
    chk("s1_addr", imem_addr, 32'd4);
    cycle(1, 0, 0, 0, 1);
    chk("s2_pc", if_pc, 32'd8);
    chk("s2_instr", if_instr, 32'd4);
    chk("s2_addr", imem_addr, 32'd8);

    // Two-cycle freeze at pc=8
    cycle(1, 1, 0, 0, 1);
    chk("hz1_req", {31'd0, imem_req}, 32'd0);
    chk("hz1_instr", if_instr, 32'd4);
    cycle(1, 1, 0, 0, 1);
    chk("hz2_req", {31'd0, imem_req}, 32'd0);
    chk("hz2_pc", if_pc, 32'd8);
    cycle(1, 0, 0, 0, 1);
    chk("hz3_instr", if_instr, 32'd8);
    chk("hz3_pc", if_pc, 32'd12);
    chk("hz3_addr", imem_addr, 32'd12);

    // Redirect with misaligned target
    cycle(1, 0, 1, 32'h103, 1);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    cycle(1, 0, 0, 0, 1);
    chk("br_pc", if_pc, 32'h104);
    chk("br_instr", if_instr, 32'h100);

    // Slow memory, two redirects while the fetch at 0x20 is outstanding
    cycle(1, 0, 1, 32'h20, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 32'h80, 0);
    chk("dr1_addr", imem_addr, 32'h20);
    chk("dr1_valid", {31'd0, if_valid}, 32'd0);
    cycle(1, 1, 1, 32'h90, 0);
    chk("dr2_addr", imem_addr, 32'h20);
    cycle(1, 0, 0, 0, 1);
    chk("dr3_addr", imem_addr, 32'h90);
    chk("dr3_valid", {31'd0, if_valid}, 32'd0);
    cycle(1, 0, 0, 0, 1);
    chk("dr4_pc", if_pc, 32'h94);
    chk("dr4_instr", if_instr, 32'h90);

    // Redirect and freeze together while parked
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 32'h40, 0);
    chk("hb_req", {31'd0, imem_req}, 32'd1);
    chk("hb_addr", imem_addr, 32'h40);
    chk("hb_valid", {31'd0, if_valid}, 32'd0);
    cycle(1, 0, 0, 0, 1);
    chk("hb_instr", if_instr, 32'h40);
    chk("hb_pc", if_pc, 32'h44);

    // PC wraps at the top of the address space
    cycle(1, 0, 1, 32'hFFFF_FFFD, 1);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0, 1);
    chk("wr_pc", if_pc, 32'h0);
    chk("wr_instr", if_instr, 32'hFFFF_FFFC);
    chk("wr_next", imem_addr, 32'h0);

    // Reset while a request waits for memory
    cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_pc", if_pc, 32'd0);
    chk("mr_instr", if_instr, 32'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk("mr_restart_pc", if_pc, 32'd4);
    chk("mr_restart_instr", if_instr, 32'd0);

    // Randomized traffic against the model
    mem_ident = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, h, bt, rdy;
      r   = ($urandom_range(99) != 0);
      h   = ($urandom_range(3) == 0);
      bt  = ($urandom_range(9) == 0);
      rdy = ($urandom_range(4) < 3);
      cycle(r, h, bt, $urandom, rdy);
    end
    cycle(1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
